// File: rtl/morty_elastic_stage.sv
// morty_elastic_stage: DEPTH-entry elastic buffer between two pipeline
// stages. Both handshake sides are driven only from registered state, so
// there is no combinational path from out_ready to in_ready and none from
// in_* to out_*. Flush and reset both empty the buffer within one cycle.
module morty_elastic_stage #(
  parameter int               WIDTH  = 32,
  parameter int               DEPTH  = 2,
  parameter logic [WIDTH-1:0] BUBBLE = {WIDTH{1'b0}},
  parameter int               AFULL  = DEPTH - 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       afull
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic [CW-1:0]    count_next;
  logic             push;
  logic             pop;

  // Handshake flags come only from the registered occupancy; a pop in the
  // same cycle as full never opens the input side.
  assign in_ready  = (count_reg != CW'(DEPTH));
  assign out_valid = (count_reg != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  assign count    = count_reg;
  assign afull    = (int'(count_reg) >= AFULL);
  assign out_data = out_valid ? mem[rd_ptr_reg] : BUBBLE;

  // Occupancy only changes when exactly one of push/pop fires.
  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  // Pointer and occupancy state; reset and flush both return to empty with
  // the next write landing in entry 0. Pointers wrap naturally since DEPTH
  // is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      count_reg <= count_next;
    end
  end

  // One write-enabled register per entry; contents are never cleared since
  // occupancy alone decides what is visible.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (push && (wr_ptr_reg == PW'(gi))) mem[gi] <= in_data;
    end
  end

endmodule
